// File: rtl/imem_loader.sv
// Byte-stream program loader for a 16-bit instruction memory.
// Holds the processor in reset until a complete program image has been written.
module imem_loader #(
    parameter int DEPTH_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [15:0] imem_addr,
    output logic [15:0] imem_wdata,
    output logic        cpu_reset,
    output logic        load_done,
    output logic        load_error
);

    typedef enum logic [2:0] {
        CNT_LO, CNT_HI, W_LO, W_HI, WRITE, DONE, ERR
    } state_t;

    localparam logic [16:0]      CAP = 17'(1) << DEPTH_W;
    localparam logic [DEPTH_W:0] ONE = 1;

    state_t           state;
    state_t           state_n;
    logic [15:0]      count;
    logic [DEPTH_W:0] idx;
    logic [15:0]      wdata;
    logic [15:0]      addr_q;
    logic [15:0]      data_q;
    logic             xfer;
    logic [15:0]      count_n;
    logic [DEPTH_W:0] idx_inc;

    assign rx_ready = (state == CNT_LO) || (state == CNT_HI) ||
                      (state == W_LO)   || (state == W_HI);
    assign xfer     = rx_valid && rx_ready && !reset;
    assign count_n  = {rx_data, count[7:0]};
    assign idx_inc  = idx + ONE;

    assign imem_we    = (state == WRITE) && !reset;
    assign imem_addr  = addr_q;
    assign imem_wdata = data_q;
    assign cpu_reset  = (state != DONE);
    assign load_done  = (state == DONE);
    assign load_error = (state == ERR);

    always_ff @(posedge clk) begin
        if (reset) state <= CNT_LO;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            CNT_LO: if (xfer) state_n = CNT_HI;
            CNT_HI: begin
                if (xfer) begin
                    if (count_n == 16'd0)         state_n = DONE;
                    else if ({1'b0, count_n} > CAP) state_n = ERR;
                    else                          state_n = W_LO;
                end
            end
            W_LO:  if (xfer) state_n = W_HI;
            W_HI:  if (xfer) state_n = WRITE;
            WRITE: state_n = (16'(idx_inc) == count) ? DONE : W_LO;
            DONE:  state_n = DONE;
            ERR:   state_n = ERR;
            default: state_n = CNT_LO;
        endcase
    end

    // Output address/data are only loaded when a word completes, so they
    // stay put between write strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            idx    <= '0;
            wdata  <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            unique case (state)
                CNT_LO: if (xfer) count[7:0]  <= rx_data;
                CNT_HI: if (xfer) count[15:8] <= rx_data;
                W_LO:   if (xfer) wdata[7:0]  <= rx_data;
                W_HI: begin
                    if (xfer) begin
                        wdata[15:8] <= rx_data;
                        addr_q      <= 16'({idx, 1'b0});
                        data_q      <= {rx_data, wdata[7:0]};
                    end
                end
                WRITE:   idx <= idx_inc;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (DEPTH_W = 8).
// A monitor logs every write strobe; the main sequence checks against hand values.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_we;
    logic [15:0] imem_addr;
    logic [15:0] imem_wdata;
    logic        cpu_reset;
    logic        load_done;
    logic        load_error;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    logic [15:0] wr_addr[$];
    logic [15:0] wr_data[$];
    int base;

    imem_loader #(.DEPTH_W(8)) dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_reset(cpu_reset), .load_done(load_done), .load_error(load_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_we) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            @(posedge clk);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int waited = 0;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!rx_ready) chk("send_timeout", 32'(rx_ready), 32'd1);
        else @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        rx_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic chk_reset_outs(input string p);
        @(negedge clk);
        chk({p, "_rdy"},  32'(rx_ready),   32'd1);
        chk({p, "_we"},   32'(imem_we),    32'd0);
        chk({p, "_addr"}, 32'(imem_addr),  32'd0);
        chk({p, "_wd"},   32'(imem_wdata), 32'd0);
        chk({p, "_cpur"}, 32'(cpu_reset),  32'd1);
        chk({p, "_done"}, 32'(load_done),  32'd0);
        chk({p, "_err"},  32'(load_error), 32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk_reset_outs("rst");

        // two words, continuous valid
        base = wr_addr.size();
        send(8'h02); send(8'h00);
        send(8'h34); send(8'h12);
        send(8'h78); send(8'h56);
        idle(3);
        chk("t1_nwr",  32'(wr_addr.size() - base), 32'd2);
        chk("t1_a0",   32'(wr_addr[base]),     32'h0000);
        chk("t1_d0",   32'(wr_data[base]),     32'h1234);
        chk("t1_a1",   32'(wr_addr[base + 1]), 32'h0002);
        chk("t1_d1",   32'(wr_data[base + 1]), 32'h5678);
        @(negedge clk);
        chk("t1_done", 32'(load_done), 32'd1);
        chk("t1_cpur", 32'(cpu_reset), 32'd0);
        chk("t1_rdy",  32'(rx_ready),  32'd0);
        chk("t1_hold", 32'({imem_addr, imem_wdata}), 32'h0002_5678);

        // empty program
        do_reset();
        base = wr_addr.size();
        send(8'h00); send(8'h00);
        @(negedge clk);
        rx_valid = 1'b0;
        chk("t2_done", 32'(load_done), 32'd1);
        chk("t2_cpur", 32'(cpu_reset), 32'd0);
        idle(2);
        chk("t2_nwr",  32'(wr_addr.size() - base), 32'd0);

        // count 257 exceeds capacity
        do_reset();
        base = wr_addr.size();
        send(8'h01); send(8'h01);
        @(negedge clk);
        rx_data = 8'h33;
        repeat (6) @(negedge clk);
        rx_valid = 1'b0;
        chk("t3_err",  32'(load_error), 32'd1);
        chk("t3_cpur", 32'(cpu_reset),  32'd1);
        chk("t3_rdy",  32'(rx_ready),   32'd0);
        chk("t3_done", 32'(load_done),  32'd0);
        chk("t3_nwr",  32'(wr_addr.size() - base), 32'd0);

        // full capacity: 256 words, word i = {i ^ 8'hA5, i}
        do_reset();
        base = wr_addr.size();
        send(8'h00); send(8'h01);
        for (int i = 0; i < 256; i++) begin
            send(8'(i));
            send(8'(i) ^ 8'hA5);
        end
        idle(3);
        chk("t4_nwr",   32'(wr_addr.size() - base), 32'd256);
        chk("t4_a0",    32'(wr_addr[base]),       32'h0000);
        chk("t4_d0",    32'(wr_data[base]),       32'hA500);
        chk("t4_a100",  32'(wr_addr[base + 100]), 32'h00C8);
        chk("t4_d100",  32'(wr_data[base + 100]), 32'hC164);
        chk("t4_alast", 32'(wr_addr[base + 255]), 32'h01FE);
        chk("t4_dlast", 32'(wr_data[base + 255]), 32'h5AFF);
        chk("t4_done",  32'(load_done), 32'd1);

        // random rx_valid gaps
        do_reset();
        base = wr_addr.size();
        idle(int'($urandom_range(0, 3))); send(8'h01);
        idle(int'($urandom_range(1, 3))); send(8'h00);
        idle(int'($urandom_range(1, 3))); send(8'hCD);
        idle(int'($urandom_range(1, 3))); send(8'hAB);
        idle(4);
        chk("t5_nwr",  32'(wr_addr.size() - base), 32'd1);
        chk("t5_wr",   32'({wr_addr[base], wr_data[base]}), 32'h0000_ABCD);
        chk("t5_done", 32'(load_done), 32'd1);

        // reset mid-word with a byte offered during reset
        do_reset();
        base = wr_addr.size();
        send(8'h02); send(8'h00); send(8'h11);
        @(negedge clk);
        reset    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        @(negedge clk);
        reset    = 1'b0;
        rx_valid = 1'b0;
        chk_reset_outs("t6");
        send(8'h01); send(8'h00);
        send(8'hEF); send(8'hBE);
        idle(3);
        chk("t6_nwr",  32'(wr_addr.size() - base), 32'd1);
        chk("t6_wr",   32'({wr_addr[base], wr_data[base]}), 32'h0000_BEEF);
        chk("t6_done", 32'(load_done), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
